ma_dmem_ctrl: RTL

Memory-access stage controller for the RV32IM pipeline. It consumes the EX/MA pipeline register outputs and drives a multi-cycle data memory over a request/ready handshake. It performs store byte-lane steering and load alignment with sign/zero extension, and returns the formatted load data to the MA/WB register. While a memory transaction is outstanding, it asserts BUSYWAIT to stall the pipeline.

---
 rtl/ma_pkg.sv | 23 ++
 rtl/ma_load_align.sv | 33 +++
 rtl/ma_dmem_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ma_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// byte-enable patterns, plus the alignment rule used when an access is offered.
package ma_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_B    = 2'b01;
    localparam logic [1:0] MEM_H    = 2'b10;
    localparam logic [1:0] MEM_W    = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        return ((size == MEM_H) && addrLo[0]) || ((size == MEM_W) && (addrLo != 2'b00));
    endfunction

endpackage

// File: rtl/ma_load_align.sv
// Load formatter: picks the addressed byte/half lane out of the memory word
// and sign- or zero-extends it to 32 bits.
module ma_load_align
    import ma_pkg::*;
(
    input  logic [31:0] readData_i,
    input  logic [1:0]  addrLo_i,
    input  logic [1:0]  memRead_i,
    input  logic        loadUnsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        case (addrLo_i)
            2'd0:    byteLane = readData_i[7:0];
            2'd1:    byteLane = readData_i[15:8];
            2'd2:    byteLane = readData_i[23:16];
            default: byteLane = readData_i[31:24];
        endcase
        halfLane = addrLo_i[1] ? readData_i[31:16] : readData_i[15:0];

        // Word loads ignore loadUnsigned_i; there is nothing to extend.
        case (memRead_i)
            MEM_B:   result_o = loadUnsigned_i ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
            MEM_H:   result_o = loadUnsigned_i ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
            default: result_o = readData_i;
        endcase
    end

endmodule

// File: rtl/ma_dmem_ctrl.sv
// Memory-access stage controller: steers stores, issues one request per
// instruction to a multi-cycle data memory, times it out, and formats loads.
module ma_dmem_ctrl
    import ma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic [1:0]  MEM_WRITE,
    input  logic [1:0]  MEM_READ,
    input  logic        LOAD_UNSIGNED,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    output logic        DMEM_READ,
    output logic        DMEM_WRITE,
    input  logic [31:0] DMEM_READDATA,
    input  logic        DMEM_READY,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        MEM_FAULT
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   dmemAddr_q, dmemAddr_d;
    logic [31:0]   dmemWdata_q, dmemWdata_d;
    logic [3:0]    dmemBe_q, dmemBe_d;
    logic          dmemRead_q, dmemRead_d;
    logic          dmemWrite_q, dmemWrite_d;
    logic [31:0]   readData_q, readData_d;
    logic          fault_q, fault_d;
    logic [1:0]    addrLo_q, addrLo_d;
    logic [1:0]    loadType_q, loadType_d;
    logic          loadUnsigned_q, loadUnsigned_d;

    logic          isStore;
    logic [1:0]    opSize;
    logic          opPresent;
    logic          opMisaligned;
    logic          startOp;
    logic [31:0]   wdataSteer;
    logic [3:0]    beSteer;
    logic [31:0]   alignedData;

    // A store takes priority over a simultaneous load, so its size decides alignment.
    assign isStore      = (MEM_WRITE != MEM_NONE);
    assign opSize       = isStore ? MEM_WRITE : MEM_READ;
    assign opPresent    = (opSize != MEM_NONE);
    assign opMisaligned = isMisaligned(opSize, ADDRESS[1:0]);
    assign startOp      = (state_q == ST_IDLE) && opPresent && !opMisaligned;

    assign BUSYWAIT   = RESET && (startOp || (state_q == ST_ACCESS));
    assign MISALIGNED = RESET && (state_q == ST_IDLE) && opPresent && opMisaligned;

    always_comb begin
        case (opSize)
            MEM_B: begin
                wdataSteer = {4{WRITE_DATA[7:0]}};
                beSteer    = BE_BYTE << ADDRESS[1:0];
            end
            MEM_H: begin
                wdataSteer = {2{WRITE_DATA[15:0]}};
                beSteer    = BE_HALF << {ADDRESS[1], 1'b0};
            end
            MEM_W: begin
                wdataSteer = WRITE_DATA;
                beSteer    = BE_WORD;
            end
            default: begin
                wdataSteer = WRITE_DATA;
                beSteer    = BE_NONE;
            end
        endcase
    end

    ma_load_align u_load_align (
        .readData_i     (DMEM_READDATA),
        .addrLo_i       (addrLo_q),
        .memRead_i      (loadType_q),
        .loadUnsigned_i (loadUnsigned_q),
        .result_o       (alignedData)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmemAddr_d     = dmemAddr_q;
        dmemWdata_d    = dmemWdata_q;
        dmemBe_d       = dmemBe_q;
        dmemRead_d     = dmemRead_q;
        dmemWrite_d    = dmemWrite_q;
        readData_d     = readData_q;
        fault_d        = 1'b0;
        addrLo_d       = addrLo_q;
        loadType_d     = loadType_q;
        loadUnsigned_d = loadUnsigned_q;

        case (state_q)
            ST_IDLE: begin
                if (startOp) begin
                    state_d        = ST_ACCESS;
                    cnt_d          = CNT_LOAD;
                    dmemAddr_d     = {ADDRESS[31:2], 2'b00};
                    dmemWdata_d    = wdataSteer;
                    dmemBe_d       = beSteer;
                    dmemRead_d     = !isStore;
                    dmemWrite_d    = isStore;
                    addrLo_d       = ADDRESS[1:0];
                    loadType_d     = MEM_READ;
                    loadUnsigned_d = LOAD_UNSIGNED;
                end
            end
            ST_ACCESS: begin
                // READY is checked first so a completion on the last allowed cycle is not a fault.
                if (DMEM_READY) begin
                    if (dmemRead_q) begin
                        readData_d = alignedData;
                    end
                    dmemRead_d  = 1'b0;
                    dmemWrite_d = 1'b0;
                    state_d     = ST_DONE;
                end else if (cnt_q == CW'(1)) begin
                    dmemRead_d  = 1'b0;
                    dmemWrite_d = 1'b0;
                    fault_d     = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            dmemAddr_q     <= '0;
            dmemWdata_q    <= '0;
            dmemBe_q       <= BE_NONE;
            dmemRead_q     <= 1'b0;
            dmemWrite_q    <= 1'b0;
            readData_q     <= '0;
            fault_q        <= 1'b0;
            addrLo_q       <= 2'b00;
            loadType_q     <= MEM_NONE;
            loadUnsigned_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmemAddr_q     <= dmemAddr_d;
            dmemWdata_q    <= dmemWdata_d;
            dmemBe_q       <= dmemBe_d;
            dmemRead_q     <= dmemRead_d;
            dmemWrite_q    <= dmemWrite_d;
            readData_q     <= readData_d;
            fault_q        <= fault_d;
            addrLo_q       <= addrLo_d;
            loadType_q     <= loadType_d;
            loadUnsigned_q <= loadUnsigned_d;
        end
    end

    assign DMEM_ADDR    = dmemAddr_q;
    assign DMEM_WDATA   = dmemWdata_q;
    assign DMEM_BYTE_EN = dmemBe_q;
    assign DMEM_READ    = dmemRead_q;
    assign DMEM_WRITE   = dmemWrite_q;
    assign READ_DATA    = readData_q;
    assign MEM_FAULT    = fault_q;

endmodule
